scr1_mem_port_arbiter: RTL

Two-master to one-slave arbiter on the SCR1 memory interface (req/req_ack/cmd/addr/resp). It lets the instruction fetch path (M0, read-only) and the data path (M1, read/write) share a single memory port, such as the TCM or the AXI bridge input. It tracks one outstanding transaction and routes the response back to its owner. It supports back-to-back pipelining on an RDY_OK response.

---
 rtl/scr1_mem_arb_pkg.sv | 7 +
 rtl/scr1_memif.sv | 23 ++
 rtl/scr1_arb_grant2.sv | 37 +++
 rtl/scr1_mem_port_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/scr1_mem_arb_pkg.sv
// Arbiter-local types: transaction FSM state and owner of the outstanding transaction.
package scr1_mem_arb_pkg;

  typedef enum logic {ARB_ADDR, ARB_DATA} type_scr1_arb_fsm_e;
  typedef enum logic {ARB_M0, ARB_M1}     type_scr1_arb_own_e;

endpackage

// File: rtl/scr1_memif.sv
// Shared SCR1 memory interface types: command, access width and response codes.
package scr1_memif;

  typedef enum logic [1:0] {
    SCR1_MEM_CMD_RD    = 2'd0,
    SCR1_MEM_CMD_WR    = 2'd1,
    SCR1_MEM_CMD_ERROR = 2'd3
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'd0,
    SCR1_MEM_WIDTH_HWORD = 2'd1,
    SCR1_MEM_WIDTH_WORD  = 2'd2,
    SCR1_MEM_WIDTH_ERROR = 2'd3
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'd0,
    SCR1_MEM_RESP_RDY_OK = 2'd1,
    SCR1_MEM_RESP_RDY_ER = 2'd2
  } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_arb_grant2.sv
// Two-way grant: fixed M1 priority, or round robin on contention when SCR1_MEM_ARB_RR_EN is defined.
module scr1_arb_grant2
  import scr1_mem_arb_pkg::*;
(
`ifdef SCR1_MEM_ARB_RR_EN
  input  logic               clk,
  input  logic               rst,
  input  logic               accept,
  input  logic               m0_req,
`endif
  input  logic               m1_req,
  output type_scr1_arb_own_e gnt
);

`ifdef SCR1_MEM_ARB_RR_EN
  type_scr1_arb_own_e rr_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= ARB_M0;
    end else if (accept) begin
      rr_last <= gnt;
    end
  end

  // On contention the master that did not win last time goes first.
  always_comb begin
    gnt = m1_req ? ARB_M1 : ARB_M0;
    if (m0_req && m1_req) begin
      gnt = (rr_last == ARB_M1) ? ARB_M0 : ARB_M1;
    end
  end
`else
  assign gnt = m1_req ? ARB_M1 : ARB_M0;
`endif

endmodule

// File: rtl/scr1_mem_port_arbiter.sv
// Two-master to one-slave SCR1 memory port arbiter with one outstanding transaction.
// Optional round-robin grant under SCR1_MEM_ARB_RR_EN (default: fixed M1 priority).
module scr1_mem_port_arbiter
  import scr1_memif::*, scr1_mem_arb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  output logic                 m0_req_ack,
  input  type_scr1_mem_cmd_e   m0_cmd,
  input  logic [AWIDTH-1:0]    m0_addr,
  output logic [DWIDTH-1:0]    m0_rdata,
  output type_scr1_mem_resp_e  m0_resp,
  input  logic                 m1_req,
  output logic                 m1_req_ack,
  input  type_scr1_mem_cmd_e   m1_cmd,
  input  type_scr1_mem_width_e m1_width,
  input  logic [AWIDTH-1:0]    m1_addr,
  input  logic [DWIDTH-1:0]    m1_wdata,
  output logic [DWIDTH-1:0]    m1_rdata,
  output type_scr1_mem_resp_e  m1_resp,
  output logic                 port_req,
  input  logic                 port_req_ack,
  output type_scr1_mem_cmd_e   port_cmd,
  output type_scr1_mem_width_e port_width,
  output logic [AWIDTH-1:0]    port_addr,
  output logic [DWIDTH-1:0]    port_wdata,
  input  logic [DWIDTH-1:0]    port_rdata,
  input  type_scr1_mem_resp_e  port_resp,
  output type_scr1_arb_fsm_e   dbg_fsm
);

  // Handshake: a request transfers in the cycle where req and req_ack are both high;
  // until then a master may change or drop its request freely. A response is a single
  // cycle with resp != NOTRDY; rdata is meaningful only when resp == RDY_OK.

  type_scr1_arb_fsm_e fsm;
  type_scr1_arb_own_e own;
  type_scr1_arb_own_e gnt;
  logic               accept_window;
  logic               port_accept;

  scr1_arb_grant2 u_grant (
`ifdef SCR1_MEM_ARB_RR_EN
    .clk    (clk),
    .rst    (rst),
    .accept (port_accept),
    .m0_req (m0_req),
`endif
    .m1_req (m1_req),
    .gnt    (gnt)
  );

  // The closing RDY_OK beat doubles as an accept slot; RDY_ER does not.
  assign accept_window = (fsm == ARB_ADDR) || (port_resp == SCR1_MEM_RESP_RDY_OK);
  assign port_req      = ~rst & accept_window & (m0_req | m1_req);
  assign port_accept   = port_req & port_req_ack;
  assign m0_req_ack    = port_accept & (gnt == ARB_M0);
  assign m1_req_ack    = port_accept & (gnt == ARB_M1);

  always_comb begin
    port_cmd   = SCR1_MEM_CMD_ERROR;
    port_width = SCR1_MEM_WIDTH_ERROR;
    port_addr  = '0;
    port_wdata = '0;
    if (m0_req || m1_req) begin
      if (gnt == ARB_M1) begin
        port_cmd   = m1_cmd;
        port_width = m1_width;
        port_addr  = m1_addr;
        port_wdata = m1_wdata;
      end else begin
        port_cmd   = m0_cmd;
        port_width = SCR1_MEM_WIDTH_WORD;
        port_addr  = m0_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm <= ARB_ADDR;
      own <= ARB_M0;
    end else if (port_accept) begin
      fsm <= ARB_DATA;
      own <= gnt;
    end else if ((fsm == ARB_DATA) && (port_resp != SCR1_MEM_RESP_NOTRDY)) begin
      fsm <= ARB_ADDR;
    end
  end

  assign m0_resp  = ((fsm == ARB_DATA) && (own == ARB_M0)) ? port_resp : SCR1_MEM_RESP_NOTRDY;
  assign m1_resp  = ((fsm == ARB_DATA) && (own == ARB_M1)) ? port_resp : SCR1_MEM_RESP_NOTRDY;
  assign m0_rdata = port_rdata;
  assign m1_rdata = port_rdata;
  assign dbg_fsm  = fsm;

endmodule
